// File: rtl/alu_pkg.sv
// Shared opcode, mode and flag definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_OR     = 3'd1,
    OP_SUB    = 3'd2,
    OP_XOR    = 3'd3,
    OP_AND    = 3'd4,
    OP_SHL    = 3'd5,
    OP_SHR    = 3'd6,
    OP_PASS_B = 3'd7
  } alu_op_e;

  localparam logic [1:0] MODE_AB     = 2'd0;
  localparam logic [1:0] MODE_AB_WR  = 2'd1;
  localparam logic [1:0] MODE_ACC_WR = 2'd2;
  localparam logic [1:0] MODE_ACC    = 2'd3;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  function automatic logic mode_uses_acc(input logic [1:0] mode);
    return (mode == MODE_ACC_WR) || (mode == MODE_ACC);
  endfunction

  function automatic logic mode_writes_acc(input logic [1:0] mode);
    return (mode == MODE_AB_WR) || (mode == MODE_ACC_WR);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {V,N,Z,C} flags, with optional
// unsigned saturation of ADD/SUB.
module alu_core
  import alu_pkg::*;
#(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  alu_op_e      op,
  output logic [N-1:0] result,
  output logic [3:0]   flags
);

  localparam logic [N-1:0] SHIFT_LIMIT = N'(N);

  logic [N:0]   sum;
  logic [N:0]   diff;
  logic [N-1:0] raw;
  logic         carry;
  logic         ovf;

  // Compute raw result, carry/borrow and overflow, then apply saturation.
  always_comb begin
    sum    = {1'b0, x} + {1'b0, y};
    diff   = {1'b0, x} - {1'b0, y};
    raw    = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    result = '0;
    flags  = 4'b0000;

    case (op)
      OP_ADD: begin
        raw   = sum[N-1:0];
        carry = sum[N];
        ovf   = (x[N-1] == y[N-1]) && (sum[N-1] != x[N-1]);
      end
      OP_SUB: begin
        raw   = diff[N-1:0];
        carry = diff[N];
        ovf   = (x[N-1] != y[N-1]) && (diff[N-1] != x[N-1]);
      end
      OP_OR:  raw = x | y;
      OP_XOR: raw = x ^ y;
      OP_AND: raw = x & y;
      OP_SHL: begin
        if (y >= SHIFT_LIMIT) raw = '0;
        else                  raw = x << y;
      end
      OP_SHR: begin
        if (y >= SHIFT_LIMIT) raw = '0;
        else                  raw = x >> y;
      end
      OP_PASS_B: raw = y;
      default:   raw = '0;
    endcase

    // Carry still reports the raw carry/borrow when clamping.
    if (SATURATE && carry && (op == OP_ADD))      result = '1;
    else if (SATURATE && carry && (op == OP_SUB)) result = '0;
    else                                          result = raw;

    flags[FLAG_C] = carry;
    flags[FLAG_Z] = (result == '0);
    flags[FLAG_N] = result[N-1];
    flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered valid/ready ALU with accumulator: operand muxing, result
// register and accumulator around the combinational alu_core.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N        = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [1:0]   in_mode,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_flags,
  output logic [N-1:0] acc_out
);

  logic         out_valid_q, out_valid_d;
  logic [N-1:0] result_q,    result_d;
  logic [3:0]   flags_q,     flags_d;
  logic [N-1:0] acc_q,       acc_d;

  logic         accept;
  logic [N-1:0] op_x;
  logic [N-1:0] core_result;
  logic [3:0]   core_flags;

  assign in_ready   = !out_valid_q || out_ready;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_flags  = flags_q;
  assign acc_out    = acc_q;

  alu_core #(
    .N        (N),
    .SATURATE (SATURATE)
  ) u_core (
    .x      (op_x),
    .y      (in_b),
    .op     (alu_op_e'(in_op)),
    .result (core_result),
    .flags  (core_flags)
  );

  // Handshake and next-state selection; result/flags hold when idle.
  always_comb begin
    accept      = in_valid && in_ready;
    op_x        = in_a;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    flags_d     = flags_q;
    acc_d       = acc_q;

    if (mode_uses_acc(in_mode)) op_x = acc_q;
    else                        op_x = in_a;

    if (accept) begin
      out_valid_d = 1'b1;
      result_d    = core_result;
      flags_d     = core_flags;
      if (mode_writes_acc(in_mode)) acc_d = core_result;
      else                          acc_d = acc_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset discards any pending result and in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= 4'b0000;
      acc_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      acc_q       <= acc_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench: a plain-arithmetic reference model drives checks on
// two instances (SATURATE=0 and SATURATE=1) sharing the same stimulus.
module tb_alu_pipe;

  localparam int NW   = 4;
  localparam int M    = 16;
  localparam int HALF = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic [2:0]    in_op;
  logic [1:0]    in_mode;
  logic [NW-1:0] in_a;
  logic [NW-1:0] in_b;
  logic          out_ready;

  logic          in_ready_w  [2];
  logic          out_valid_w [2];
  logic [NW-1:0] out_result_w[2];
  logic [3:0]    out_flags_w [2];
  logic [NW-1:0] acc_w       [2];

  int checks   = 0;
  int failures = 0;

  alu_pipe #(.N(NW), .SATURATE(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
    .in_op(in_op), .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_w[0]), .out_ready(out_ready),
    .out_result(out_result_w[0]), .out_flags(out_flags_w[0]), .acc_out(acc_w[0])
  );

  alu_pipe #(.N(NW), .SATURATE(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
    .in_op(in_op), .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid_w[1]), .out_ready(out_ready),
    .out_result(out_result_w[1]), .out_flags(out_flags_w[1]), .acc_out(acc_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {V,N,Z,C,result} from integer arithmetic.
  function automatic logic [7:0] ref_op(input int x, input int y, input int op, input bit sat);
    int r, sx, sy, t;
    bit c, v;
    logic [3:0] rr;
    sx = (x >= HALF) ? x - M : x;
    sy = (y >= HALF) ? y - M : y;
    c = 1'b0; v = 1'b0; r = 0;
    case (op)
      0: begin
        t = sx + sy; v = (t > HALF - 1) || (t < -HALF);
        r = x + y; c = (r >= M);
        if (c) r = r - M;
        if (sat && c) r = M - 1;
      end
      1: r = x | y;
      2: begin
        t = sx - sy; v = (t > HALF - 1) || (t < -HALF);
        c = (x < y);
        r = c ? x - y + M : x - y;
        if (sat && c) r = 0;
      end
      3: r = x ^ y;
      4: r = x & y;
      5: r = (y >= NW) ? 0 : ((x << y) % M);
      6: r = (y >= NW) ? 0 : (x >> y);
      7: r = y;
      default: r = 0;
    endcase
    rr = r[3:0];
    return {v, rr[3], (r == 0), c, rr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_mode = 2'd1;
    in_a = 4'h5; in_b = 4'h5; out_ready = 1'b1;
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d], in_ready_w[d]} !== {1'b0, 4'h0, 4'h0, 4'h0, 1'b1}) begin
        failures++;
        $display("FAIL reset dut%0d: got v=%b r=%h f=%b acc=%h rdy=%b want v=0 r=0 f=0000 acc=0 rdy=1",
                 d, out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d], in_ready_w[d]);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [3:0] ta[3]  = '{4'hF, 4'h3, 4'h8};
    logic [3:0] tb_[3] = '{4'h1, 4'h5, 4'h1};
    logic [2:0] to[3]  = '{3'd0, 3'd2, 3'd2};
    logic [7:0] e0[3]  = '{{4'b0011, 4'h0}, {4'b0101, 4'hE}, {4'b1000, 4'h7}};
    logic [7:0] e1[3]  = '{{4'b0101, 4'hF}, {4'b0011, 4'h0}, {4'b1000, 4'h7}};
    logic [7:0] want;
    out_ready = 1'b1; in_mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = ta[i]; in_b = tb_[i]; in_op = to[i];
      step();
      for (int d = 0; d < 2; d++) begin
        want = (d == 0) ? e0[i] : e1[i];
        checks++;
        if ({out_valid_w[d], out_flags_w[d], out_result_w[d]} !== {1'b1, want}) begin
          failures++;
          $display("FAIL add_sub dut%0d case%0d: got v=%b f=%b r=%h want v=1 f=%b r=%h",
                   d, i, out_valid_w[d], out_flags_w[d], out_result_w[d], want[7:4], want[3:0]);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_shifts();
    logic [2:0] to[3]  = '{3'd5, 3'd6, 3'd5};
    logic [3:0] tb_[3] = '{4'd2, 4'd1, 4'd4};
    logic [7:0] ex[3]  = '{{4'b0100, 4'b1100}, {4'b0000, 4'b0001}, {4'b0010, 4'b0000}};
    out_ready = 1'b1; in_mode = 2'd0; in_a = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = to[i]; in_b = tb_[i];
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_flags_w[d], out_result_w[d]} !== ex[i]) begin
          failures++;
          $display("FAIL shift dut%0d case%0d: got f=%b r=%b want f=%b r=%b",
                   d, i, out_flags_w[d], out_result_w[d], ex[i][7:4], ex[i][3:0]);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_accumulate();
    logic [1:0] tm[3]  = '{2'd1, 2'd2, 2'd3};
    logic [2:0] to[3]  = '{3'd0, 3'd0, 3'd2};
    logic [3:0] ta[3]  = '{4'd2, 4'd0, 4'd0};
    logic [3:0] tb_[3] = '{4'd3, 4'd4, 4'd1};
    logic [3:0] er[3]  = '{4'd5, 4'd9, 4'd8};
    logic [3:0] ea[3]  = '{4'd5, 4'd9, 4'd9};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_mode = tm[i]; in_op = to[i]; in_a = ta[i]; in_b = tb_[i];
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_result_w[d], acc_w[d]} !== {er[i], ea[i]}) begin
          failures++;
          $display("FAIL accumulate dut%0d step%0d: got r=%0d acc=%0d want r=%0d acc=%0d",
                   d, i, out_result_w[d], acc_w[d], er[i], ea[i]);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd0; in_op = 3'd0; in_a = 4'd1; in_b = 4'd2;
    step();
    in_op = 3'd3; in_a = 4'd6; in_b = 4'd3;
    for (int c = 0; c < 3; c++) begin
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({in_ready_w[d], out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d]} !== {1'b0, 1'b1, 4'd3, 4'b0000, 4'd9}) begin
          failures++;
          $display("FAIL stall dut%0d cyc%0d: got rdy=%b v=%b r=%h f=%b acc=%h want rdy=0 v=1 r=3 f=0000 acc=9",
                   d, c, in_ready_w[d], out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d]);
        end
      end
    end
    out_ready = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_w[d] !== 1'b1) begin
        failures++;
        $display("FAIL release_ready dut%0d: got %b want 1", d, in_ready_w[d]);
      end
    end
    step();
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid_w[d], out_result_w[d]} !== {1'b1, 4'd5}) begin
        failures++;
        $display("FAIL second_op dut%0d: got v=%b r=%h want v=1 r=5", d, out_valid_w[d], out_result_w[d]);
      end
    end
    step();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid_w[d], out_result_w[d]} !== {1'b0, 4'd5}) begin
        failures++;
        $display("FAIL drain_hold dut%0d: got v=%b r=%h want v=0 r=5", d, out_valid_w[d], out_result_w[d]);
      end
    end
  endtask

  task automatic test_reset_midstall();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 2'd1; in_op = 3'd0; in_a = 4'd4; in_b = 4'd5;
    step();
    in_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid_w[d], acc_w[d]} !== {1'b1, 4'd9}) begin
        failures++;
        $display("FAIL pre_reset dut%0d: got v=%b acc=%h want v=1 acc=9", d, out_valid_w[d], acc_w[d]);
      end
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({out_valid_w[d], acc_w[d], out_flags_w[d], in_ready_w[d]} !== {1'b0, 4'd0, 4'b0000, 1'b1}) begin
        failures++;
        $display("FAIL midstall_reset dut%0d: got v=%b acc=%h f=%b rdy=%b want v=0 acc=0 f=0000 rdy=1",
                 d, out_valid_w[d], acc_w[d], out_flags_w[d], in_ready_w[d]);
      end
    end
  endtask

  task automatic test_random();
    int         m_acc[2];
    logic [3:0] m_res[2];
    logic [3:0] m_fl[2];
    bit         m_v;
    bit         exp_rdy;
    int         x;
    logic [7:0] r;
    rst_n = 1'b0; in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    m_v = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_acc[d] = 0; m_res[d] = 4'h0; m_fl[d] = 4'h0;
    end
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 3'($urandom_range(0, 7));
      in_mode   = 2'($urandom_range(0, 3));
      in_a      = 4'($urandom);
      in_b      = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 5)) : 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      exp_rdy = !m_v || out_ready;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (in_ready_w[d] !== exp_rdy) begin
          failures++;
          $display("FAIL rnd_ready dut%0d it%0d: got %b want %b", d, i, in_ready_w[d], exp_rdy);
        end
      end
      if (in_valid && exp_rdy) begin
        for (int d = 0; d < 2; d++) begin
          x = (in_mode >= 2'd2) ? m_acc[d] : int'(in_a);
          r = ref_op(x, int'(in_b), int'(in_op), (d == 1));
          m_res[d] = r[3:0];
          m_fl[d]  = r[7:4];
          if (in_mode == 2'd1 || in_mode == 2'd2) m_acc[d] = int'(r[3:0]);
        end
        m_v = 1'b1;
      end else if (out_ready) begin
        m_v = 1'b0;
      end
      step();
      for (int d = 0; d < 2; d++) begin
        checks++;
        if ({out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d]} !== {m_v, m_res[d], m_fl[d], 4'(m_acc[d])}) begin
          failures++;
          $display("FAIL rnd dut%0d it%0d: got v=%b r=%h f=%b acc=%h want v=%b r=%h f=%b acc=%h",
                   d, i, out_valid_w[d], out_result_w[d], out_flags_w[d], acc_w[d],
                   m_v, m_res[d], m_fl[d], 4'(m_acc[d]));
        end
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_mode = 2'd0;
    in_a = 4'd0; in_b = 4'd0; out_ready = 1'b1;
    test_reset();
    test_add_sub();
    test_shifts();
    test_accumulate();
    test_backpressure();
    test_reset_midstall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
